// File: rtl/pi_run_ctrl.sv
// Monte Carlo pi batch sequencer: gates sampling for N points, counts hits,
// issues one divide request and captures the quotient as the pi estimate.
module pi_run_ctrl #(
  parameter int CNT_W   = 27,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_num_samples,
  input  logic             i_coord_valid,
  input  logic             i_op_lt_1,
  output logic             o_sample_en,
  output logic             o_div_valid,
  output logic [CNT_W-1:0] o_div_x,
  output logic [CNT_W-1:0] o_div_y,
  input  logic             i_div_result_valid,
  input  logic [CNT_W-1:0] i_div_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W+1:0] o_pi_out
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_REQ, S_WAIT, S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_lt_cnt;
  logic [TW-1:0]    r_timer;
  logic             r_sample_en;
  logic             r_div_valid;
  logic [CNT_W-1:0] r_div_x;
  logic [CNT_W-1:0] r_div_y;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W+1:0] r_pi_out;

  logic             w_go;
  logic             w_take;
  logic [CNT_W-1:0] w_op_nxt;
  logic [CNT_W-1:0] w_lt_nxt;

  assign w_go     = i_start & ~i_abort & (i_num_samples != '0);
  assign w_take   = i_coord_valid & (r_op_cnt < r_n);
  assign w_op_nxt = r_op_cnt + CNT_W'(1);
  assign w_lt_nxt = r_lt_cnt + CNT_W'(i_op_lt_1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_op_cnt    <= '0;
      r_lt_cnt    <= '0;
      r_timer     <= '0;
      r_sample_en <= 1'b0;
      r_div_valid <= 1'b0;
      r_div_x     <= '0;
      r_div_y     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pi_out    <= '0;
    end else if (i_abort) begin
      // counters, divider operands and pi_out deliberately hold
      r_state     <= S_IDLE;
      r_sample_en <= 1'b0;
      r_div_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go) begin
            r_n         <= i_num_samples;
            r_op_cnt    <= '0;
            r_lt_cnt    <= '0;
            r_timer     <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_sample_en <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_take) begin
            r_op_cnt <= w_op_nxt;
            r_lt_cnt <= w_lt_nxt;
            if (w_op_nxt == r_n) begin
              r_sample_en <= 1'b0;
              r_div_valid <= 1'b1;
              r_div_x     <= w_op_nxt;
              r_div_y     <= w_lt_nxt;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_div_valid <= 1'b0;
          r_timer     <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_div_result_valid) begin
            r_pi_out <= {i_div_result, 2'b00};
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sample_en = r_sample_en;
  assign o_div_valid = r_div_valid;
  assign o_div_x     = r_div_x;
  assign o_div_y     = r_div_y;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_pi_out    = r_pi_out;

endmodule

// File: tb/tb_pi_run_ctrl.sv
// Bench for pi_run_ctrl: table vectors, random batches against a counting
// model, and hand sequences for abort, zero-N and mid-batch reset.
module tb_pi_run_ctrl;

  localparam int CNT_W   = 27;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic             i_abort;
  logic [CNT_W-1:0] i_num_samples;
  logic             i_coord_valid;
  logic             i_op_lt_1;
  logic             o_sample_en;
  logic             o_div_valid;
  logic [CNT_W-1:0] o_div_x;
  logic [CNT_W-1:0] o_div_y;
  logic             i_div_result_valid;
  logic [CNT_W-1:0] i_div_result;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic [CNT_W+1:0] o_pi_out;

  pi_run_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_num_samples(i_num_samples),
    .i_coord_valid(i_coord_valid),
    .i_op_lt_1(i_op_lt_1),
    .o_sample_en(o_sample_en),
    .o_div_valid(o_div_valid),
    .o_div_x(o_div_x),
    .o_div_y(o_div_y),
    .i_div_result_valid(i_div_result_valid),
    .i_div_result(i_div_result),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_pi_out(o_pi_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dv_pulses;
  int dv_fall;
  int err_rise;
  bit prev_dv  = 1'b0;
  bit prev_err = 1'b0;
  logic [CNT_W-1:0] cap_x;
  logic [CNT_W-1:0] cap_y;

  typedef struct {
    int               n;
    logic [31:0]      pat;
    int               extra;
    int               delay;
    bit               silent;
    logic [CNT_W-1:0] res;
    logic [CNT_W-1:0] ex;
    logic [CNT_W-1:0] ey;
    logic [CNT_W+1:0] epi;
    bit               eerr;
  } vec_t;

  vec_t tv[4];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (o_div_valid) begin
      dv_pulses++;
      cap_x = o_div_x;
      cap_y = o_div_y;
    end
    if (prev_dv && !o_div_valid) dv_fall = cyc;
    if (o_err && !prev_err) err_rise = cyc;
    prev_dv  = o_div_valid;
    prev_err = o_err;
  endtask

  // Runs one batch; m_ins is the model's count of inside points among the
  // first n accepted samples.
  task automatic batch(input int n, input logic [31:0] pat, input bit rnd,
                       input int extra, input int delay, input bit silent,
                       input logic [CNT_W-1:0] res, output int m_ins);
    int cnt, guard, t;
    cnt = 0; guard = 0; m_ins = 0;
    dv_pulses = 0; dv_fall = -1; err_rise = -1;
    i_num_samples = CNT_W'(n);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_sample_en", o_sample_en, 1);
    check("start_done_clr", o_done, 0);
    while (cnt < n && guard < 1000) begin
      i_coord_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_op_lt_1 = rnd ? 1'($urandom_range(0, 1)) : pat[cnt];
      if (i_coord_valid) begin
        cnt++;
        m_ins += int'(i_op_lt_1);
      end
      step();
      guard++;
    end
    check("run_bound", guard < 1000, 1);
    check("sample_en_fall", o_sample_en, 0);
    check("req_valid", o_div_valid, 1);
    for (int j = 0; j <= delay; j++) begin
      i_coord_valid = (j < extra);
      i_op_lt_1 = 1'b1;
      step();
    end
    i_coord_valid = 1'b0;
    check("wait_busy", o_busy, 1);
    if (!silent) begin
      i_div_result_valid = 1'b1;
      i_div_result = res;
      step();
      i_div_result_valid = 1'b0;
    end else begin
      t = 0;
      while (!o_done && t < TIMEOUT + 10) begin
        step();
        t++;
      end
      check("timeout_latency", 64'(err_rise - dv_fall), 64'(TIMEOUT));
    end
    check("done_level", o_done, 1);
    check("done_busy", o_busy, 0);
    check("div_pulses", dv_pulses, 1);
  endtask

  initial begin
    int ins, n, d, ex;
    logic [CNT_W-1:0] r;
    logic [CNT_W+1:0] prior;

    tv[0] = '{8, 32'hEE, 0, 5, 1'b0, 27'h0C00000, 27'd8, 27'd6,
              29'h3000000, 1'b0};
    tv[1] = '{4, 32'h5, 3, 2, 1'b0, 27'h1, 27'd4, 27'd2,
              29'h4, 1'b0};
    tv[2] = '{1, 32'h1, 0, 0, 1'b0, 27'h7FFFFFF, 27'd1, 27'd1,
              29'h1FFFFFFC, 1'b0};
    tv[3] = '{3, 32'h2, 1, 0, 1'b1, 27'h0, 27'd3, 27'd1,
              29'h1FFFFFFC, 1'b1};

    rst = 1'b1;
    i_start = 0; i_abort = 0; i_num_samples = '0;
    i_coord_valid = 0; i_op_lt_1 = 0;
    i_div_result_valid = 0; i_div_result = '0;
    #2;
    check("rst_sample_en", o_sample_en, 0);
    check("rst_div_valid", o_div_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_pi", o_pi_out, 0);
    #20 rst = 1'b0;
    step();

    // start with zero samples, then start together with abort
    i_num_samples = '0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("zero_n_busy", o_busy, 0);
    check("zero_n_sen", o_sample_en, 0);
    step();
    check("zero_n_busy2", o_busy, 0);
    i_num_samples = 27'd5; i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    check("start_abort_busy", o_busy, 0);
    step();
    check("start_abort_sen", o_sample_en, 0);

    foreach (tv[k]) begin
      batch(tv[k].n, tv[k].pat, 1'b0, tv[k].extra, tv[k].delay,
            tv[k].silent, tv[k].res, ins);
      check($sformatf("tv%0d_div_x", k), cap_x, tv[k].ex);
      check($sformatf("tv%0d_div_y", k), cap_y, tv[k].ey);
      check($sformatf("tv%0d_div_x_held", k), o_div_x, tv[k].ex);
      check($sformatf("tv%0d_pi", k), o_pi_out, tv[k].epi);
      check($sformatf("tv%0d_err", k), o_err, tv[k].eerr);
    end

    // abort in DONE clears done and err, pi_out holds
    prior = o_pi_out;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_done_done", o_done, 0);
    check("abort_done_err", o_err, 0);
    check("abort_done_pi", o_pi_out, prior);

    // abort mid-run; late divider results must be ignored
    dv_pulses = 0;
    i_num_samples = 27'd10; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      i_coord_valid = 1'b1; i_op_lt_1 = 1'b1;
      step();
    end
    i_coord_valid = 1'b0;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_run_busy", o_busy, 0);
    check("abort_run_sen", o_sample_en, 0);
    for (int j = 0; j < 8; j++) begin
      i_div_result_valid = 1'b1;
      i_div_result = 27'h155;
      i_coord_valid = 1'($urandom_range(0, 1));
      step();
    end
    i_div_result_valid = 1'b0; i_coord_valid = 1'b0;
    check("abort_no_req", dv_pulses, 0);
    check("abort_no_done", o_done, 0);
    check("abort_pi_hold", o_pi_out, prior);

    // random batches against the counting model
    for (int b = 0; b < 6; b++) begin
      n  = $urandom_range(1, 20);
      d  = $urandom_range(0, 40);
      ex = $urandom_range(0, 3);
      r  = CNT_W'($urandom);
      batch(n, 32'h0, 1'b1, ex, d, 1'b0, r, ins);
      check("rnd_div_x", cap_x, CNT_W'(n));
      check("rnd_div_y", cap_y, CNT_W'(ins));
      check("rnd_pi", o_pi_out, {r, 2'b00});
      check("rnd_err", o_err, 0);
    end

    // reset asserted while waiting on the divider
    i_num_samples = 27'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_coord_valid = 1'b1;
    step();
    step();
    i_coord_valid = 1'b0;
    step();
    check("pre_rst_busy", o_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_div_x", o_div_x, 0);
    check("mid_rst_div_y", o_div_y, 0);
    check("mid_rst_pi", o_pi_out, 0);
    check("mid_rst_sen", o_sample_en, 0);
    #3 rst = 1'b0;
    prev_dv = 1'b0; prev_err = 1'b0;
    batch(2, 32'h2, 1'b0, 0, 3, 1'b0, 27'h1234, ins);
    check("post_rst_div_x", cap_x, 2);
    check("post_rst_div_y", cap_y, 1);
    check("post_rst_pi", o_pi_out, 29'h48D0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
